// File: rtl/alu_result_fifo_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared ALU definitions used by the result-capture buffer and its
//   neighbours in the ALU datapath.
//   - ALU_OP_W : opcode width in bits
//   - alu_op_t : opcode enumeration carried alongside every result word
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4
  } alu_op_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// ---------------------------------------------------------------------------
// alu_result_fifo_if
//   Bundles the write-side (ALU issue stage) and read-side (consumer)
//   handshakes of alu_result_fifo.
//   Parameters: WIDTH (result word width), DEPTH (entries, power of two)
//   Write side : wr_valid, wr_ready, wr_data[WIDTH], wr_op[3]
//   Read side  : rd_valid, rd_ready, rd_data[WIDTH], rd_op[3]
//   Status     : count[$clog2(DEPTH)+1]
//   Optional   : rd_zero, rd_parity (present only with ALU_FLAGS_EN defined)
//   Modports   : slave  - the buffer itself
//                master - the environment driving writes and taking reads
// ---------------------------------------------------------------------------
interface alu_result_fifo_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  alu_op_t          wr_op;

  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  alu_op_t          rd_op;

  logic [CNT_W-1:0] count;

`ifdef ALU_FLAGS_EN
  logic             rd_zero;
  logic             rd_parity;
`endif

  modport slave (
    input  wr_valid, wr_data, wr_op, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_op, count
`ifdef ALU_FLAGS_EN
    , output rd_zero, rd_parity
`endif
  );

  modport master (
    output wr_valid, wr_data, wr_op, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_op, count
`ifdef ALU_FLAGS_EN
    , input rd_zero, rd_parity
`endif
  );

endinterface

// File: rtl/alu_result_fifo_flag_gen.sv
// ---------------------------------------------------------------------------
// alu_flag_gen
//   Combinational zero / parity generator for one ALU result word.
//   Ports:
//     data   input  WIDTH  result word
//     zero   output 1      1 when data is all zeros
//     parity output 1      XOR-reduction of data (1 = odd number of ones)
// ---------------------------------------------------------------------------
module alu_flag_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             zero,
  output logic             parity
);

  assign zero   = (data == '0);
  assign parity = ^data;

endmodule

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//   In-order result-capture buffer between the ALU issue stage and a
//   consumer that may stall. Stores up to DEPTH {result, opcode} entries.
//   Ports:
//     clk    input  rising-edge clock
//     rst_n  input  asynchronous active-low reset
//     bus    alu_result_fifo_if.slave (write/read handshakes, count, flags)
//   Behaviour:
//     - push = wr_valid && wr_ready, pop = rd_valid && rd_ready
//     - wr_ready = !full, rd_valid = !empty; both come from registered count
//     - no write-to-read bypass and no pop-to-write pass-through when full
//   Configuration macro:
//     ALU_FLAGS_EN - when defined, each entry also stores zero/parity flags
//                    computed at push and presented as rd_zero / rd_parity.
// ---------------------------------------------------------------------------
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    alu_op_t          op;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status depends only on the registered count, never on wr_valid/rd_ready.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  assign push = bus.wr_valid && !full;
  assign pop  = bus.rd_ready && !empty;

  assign bus.wr_ready = !full;
  assign bus.rd_valid = !empty;
  assign bus.count    = count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only occupancy matters.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: bus.wr_op, data: bus.wr_data};
  end

  // Head entry read straight from the array, so it holds while stalled.
  assign bus.rd_data = mem[rd_ptr].data;
  assign bus.rd_op   = mem[rd_ptr].op;

`ifdef ALU_FLAGS_EN
  logic       wr_zero;
  logic       wr_parity;
  logic [1:0] flag_mem [DEPTH];   // {zero, parity}

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .data   (bus.wr_data),
    .zero   (wr_zero),
    .parity (wr_parity)
  );

  always_ff @(posedge clk) begin
    if (push) flag_mem[wr_ptr] <= {wr_zero, wr_parity};
  end

  // Flags are forced low when empty so they read 0 out of reset.
  assign bus.rd_zero   = !empty && flag_mem[rd_ptr][1];
  assign bus.rd_parity = !empty && flag_mem[rd_ptr][0];
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
//   Self-checking bench for alu_result_fifo (WIDTH=8, DEPTH=4). A queue
//   holds the expected buffer contents; a negedge process compares every
//   output against it each cycle, and directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [2:0]       op;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  ent_t q[$];

  alu_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue semantics of a bounded FIFO.
  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    bit   do_push;
    bit   do_pop;
    ent_t e;
    if (rst_n) begin
      do_push = bus.wr_valid && (q.size() < DEPTH);
      do_pop  = bus.rd_ready && (q.size() > 0);
      e.d  = bus.wr_data;
      e.op = bus.wr_op;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("count",    32'(bus.count),    32'(q.size()));
    check("wr_ready", 32'(bus.wr_ready), 32'(q.size() < DEPTH));
    check("rd_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("rd_data", 32'(bus.rd_data), 32'(q[0].d));
      check("rd_op",   32'(bus.rd_op),   32'(q[0].op));
`ifdef ALU_FLAGS_EN
      check("rd_zero",   32'(bus.rd_zero),   32'(q[0].d == 0));
      check("rd_parity", 32'(bus.rd_parity), 32'(^q[0].d));
`endif
    end else begin
`ifdef ALU_FLAGS_EN
      check("rd_zero_empty",   32'(bus.rd_zero),   32'd0);
      check("rd_parity_empty", 32'(bus.rd_parity), 32'd0);
`endif
    end
  end

  // Apply inputs, let one rising edge pass, return 1 time unit after it.
  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] op, input logic r);
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.wr_op    = alu_op_t'(op);
    bus.rd_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 3'd0, 1'b0);
  endtask

  logic [7:0] fill_d  [4];
  logic [2:0] fill_op [4];

  initial begin
    fill_d  = '{8'h0F, 8'hF0, 8'hFF, 8'h00};
    fill_op = '{3'(OP_OR), 3'(OP_AND), 3'(OP_XOR), 3'(OP_ADD)};

    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_op    = OP_AND;
    bus.rd_ready = 1'b0;
    rst_n        = 1'b1;

    // Reset asserted mid-cycle takes effect immediately.
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_count",    32'(bus.count),    32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) idle();
    check("idle_count",    32'(bus.count),    32'd0);
    check("idle_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < 4; i++) drive(1'b1, fill_d[i], fill_op[i], 1'b0);
    check("fill_count",    32'(bus.count),    32'd4);
    check("fill_wr_ready", 32'(bus.wr_ready), 32'd0);
    drive(1'b1, 8'h55, 3'(OP_SUB), 1'b0);
    check("overflow_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(bus.rd_data), 32'(fill_d[i]));
      check("drain_op",   32'(bus.rd_op),   32'(fill_op[i]));
      drive(1'b0, 8'h00, 3'd0, 1'b1);
    end
    check("drain_count", 32'(bus.count), 32'd0);

    // Back-pressure hold.
    drive(1'b1, 8'h3C, 3'(OP_OR), 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("hold_data",  32'(bus.rd_data),  32'h3C);
      check("hold_op",    32'(bus.rd_op),    32'(OP_OR));
      check("hold_valid", 32'(bus.rd_valid), 32'd1);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b1);

    // Simultaneous push/pop at count=2 across pointer wraps.
    drive(1'b1, 8'h11, 3'(OP_ADD), 1'b0);
    drive(1'b1, 8'h22, 3'(OP_SUB), 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'($urandom), 3'($urandom_range(0, 4)), 1'b1);
      check("pp_count", 32'(bus.count), 32'd2);
    end
    drive(1'b0, 8'h00, 3'd0, 1'b1);
    drive(1'b0, 8'h00, 3'd0, 1'b1);

    // Push+pop while full: only the pop happens.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h40 + i), 3'(OP_XOR), 1'b0);
    drive(1'b1, 8'h99, 3'(OP_AND), 1'b1);
    check("fullpp_count",    32'(bus.count),    32'd3);
    check("fullpp_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("fullpp_head",     32'(bus.rd_data),  32'h41);
    repeat (3) drive(1'b0, 8'h00, 3'd0, 1'b1);

    // Reset mid-operation.
    repeat (3) drive(1'b1, 8'h77, 3'(OP_OR), 1'b0);
    bus.wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_count",    32'(bus.count),    32'd0);
    check("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 8'hA5, 3'(OP_AND), 1'b0);
    check("postrst_data",  32'(bus.rd_data), 32'hA5);
    check("postrst_count", 32'(bus.count),   32'd1);
    drive(1'b0, 8'h00, 3'd0, 1'b1);

`ifdef ALU_FLAGS_EN
    drive(1'b1, 8'h00, 3'(OP_AND), 1'b0);
    drive(1'b1, 8'h07, 3'(OP_ADD), 1'b0);
    check("flag_zero0",   32'(bus.rd_zero),   32'd1);
    check("flag_parity0", 32'(bus.rd_parity), 32'd0);
    drive(1'b0, 8'h00, 3'd0, 1'b1);
    check("flag_zero1",   32'(bus.rd_zero),   32'd0);
    check("flag_parity1", 32'(bus.rd_parity), 32'd1);
    drive(1'b0, 8'h00, 3'd0, 1'b1);
`endif

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 2000; i++)
      drive(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 4)),
            1'($urandom_range(0, 1)));

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Result-capture buffer on the consumer side of the ALU datapath. It accepts one result word plus its opcode per cycle from the ALU issue stage, using a valid/ready handshake, and stores up to DEPTH entries in order. It presents them to the downstream reader (display/register-writeback logic) with its own valid/ready handshake. The block decouples combinational ALU ops (bitwise OR/AND/XOR, add/sub) from a consumer that may stall.

## Interface
- WIDTH, 8, result word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wr_valid  input  1  ALU result present this cycle
- wr_ready  output  1  buffer can accept; equals !full
- wr_data  input  WIDTH  ALU result word
- wr_op  input  3  opcode that produced wr_data (alu_pkg::alu_op_t)
- rd_valid  output  1  head entry valid; equals !empty
- rd_ready  input  1  consumer takes head entry this cycle
- rd_data  output  WIDTH  head entry result
- rd_op  output  3  head entry opcode
- count  output  $clog2(DEPTH)+1  entries currently stored
- rd_zero, rd_parity  output  1 each  head-entry flags (ALU_FLAGS_EN only)

## Operation
- Push when wr_valid && wr_ready; pop when rd_valid && rd_ready.
- Storage is a DEPTH-entry array, with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. count tracks occupancy.
- full = (count == DEPTH); empty = (count == 0).
- rd_data/rd_op are driven from array[rd_ptr], so they hold stable while rd_valid && !rd_ready.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- Full: wr_ready=0. A simultaneous pop does not open a write slot in that cycle, so there is no pass-through; wr_ready rises the cycle after the pop.
- Empty: rd_valid=0 and rd_data is don't-care. A push into an empty buffer is not bypassed to the read side.
- wr_valid while full: no push occurs, and the source must hold the word.
- Reset (asynchronous, any time including mid-transfer): pointers and count go to 0, so wr_ready=1, rd_valid=0, count=0, rd_zero=0, rd_parity=0. Array contents are not reset. Any in-flight handshake is discarded.

## Timing
- Write-to-read latency is 1 cycle. A push at edge N gives rd_valid=1 after edge N.
- Throughput is one push and one pop per cycle.
- wr_ready, rd_valid and count are pure functions of registered state, with no combinational path from wr_valid or rd_ready.
- Outputs change only on rising clk or on assertion of rst_n low.

## Configuration
- ALU_FLAGS_EN defined:
  - Each entry additionally stores zero = (wr_data == 0) and parity = ^wr_data, computed at push.
  - rd_zero and rd_parity reflect the head entry.
  - When empty, both flags read 0.
- ALU_FLAGS_EN undefined:
  - The rd_zero and rd_parity ports are absent.
  - No flag storage is built.

## Structure
- Shared package alu_pkg holds:
  - alu_op_t enum: OP_AND=3'd0, OP_OR=3'd1, OP_XOR=3'd2, OP_ADD=3'd3, OP_SUB=3'd4.
  - ALU_OP_W=3.
- One sub-module: alu_flag_gen, a combinational zero/parity generator of parameter WIDTH, instantiated on the write side under ALU_FLAGS_EN.
- Pointer, count and handshake logic stay in the top module.

## Test plan
- Reset then idle: rst_n low mid-cycle → immediately wr_ready=1, rd_valid=0, count=0. After release, no change without wr_valid.
- Fill and drain (DEPTH=4, WIDTH=8): push 0x0F/OP_OR, 0xF0/OP_AND, 0xFF/OP_XOR, 0x00/OP_ADD with rd_ready=0.
  - count reaches 4 and wr_ready=0.
  - A 5th wr_valid is ignored.
  - Drain yields the same 4 words and opcodes in order, with count reaching 0.
- Back-pressure: one entry 0x3C held with rd_ready=0 for 5 cycles → rd_data=0x3C and rd_op=OP_OR stable, rd_valid=1 throughout.
- Simultaneous push/pop:
  - At count=2, push and pop together → count stays 2, and pointers wrap correctly over 10 consecutive cycles.
  - At full, push and pop together → only the pop occurs, count=3, and wr_ready=1 next cycle.
- Reset mid-operation: at count=3, assert rst_n low → count=0 and rd_valid=0 asynchronously. After release, push 0xA5 → it is read back as the first word.
- ALU_FLAGS_EN build: push 0x00 then 0x07.
  - Head 0x00 gives rd_zero=1, rd_parity=0.
  - After the pop, head 0x07 gives rd_zero=0, rd_parity=1.
